// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types and sizing for the decode-stage hazard scoreboard.
//           One scoreboard entry per in-flight stage after decode:
//           [0]=EX, [1]=MEM, [2]=WB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Register-address width: 8 GPRs, R0 is an ordinary register.
    localparam int REG_AW = 3;

    // Number of tracked stages after decode.
    localparam int DEPTH = 3;

    // One in-flight destination register. The field cannot be called "reg"
    // because that is a language keyword, hence regNum.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] regNum;
    } sb_entry_t;

    // Stall controller state.
    typedef enum logic [0:0] {
        HZ_IDLE  = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_t;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_cmp.sv
// ============================================================================
// Module  : hazard_cmp
// Brief   : Compares one scoreboard entry against the decode instruction's
//           source registers, qualified by its source-usage flags.
//           matchBoth implies Rs is read as well as Rt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_cmp
    import hazard_pkg::*;
(
    input  sb_entry_t         entry,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              matchRs,
    input  logic              matchBoth,
    output logic              hitRs,
    output logic              hitRt
);

    logic w_readsRs;
    logic w_rsEq;
    logic w_rtEq;

    // An instruction that reads both sources necessarily reads Rs.
    assign w_readsRs = matchRs | matchBoth;
    assign w_rsEq    = (entry.regNum == rs);
    assign w_rtEq    = (entry.regNum == rt);

    assign hitRs = w_readsRs & entry.valid & w_rsEq;
    assign hitRt = matchBoth & entry.valid & w_rtEq;

endmodule : hazard_cmp

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Tracks destination registers of in-flight instructions in a shift
//           scoreboard and stalls decode (hold PC + IF/ID, bubble into ID/EX)
//           while any decode source matches a pending write.
//           Optional macro HAZARD_STATS_EN builds a saturating counter of
//           stall cycles; without it stall_cycles is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_match_rs,
    input  logic              id_match_both,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              flush,
    output logic              stall,
    output logic              bubble,
    output logic [15:0]       stall_cycles
);

    localparam int RUN_W = $clog2(DEPTH + 1);
    localparam logic [RUN_W-1:0] c_maxRun = RUN_W'(DEPTH);

    sb_entry_t        r_entries [DEPTH];
    hz_state_t        r_state;
    logic [RUN_W-1:0] r_stallRun;

    logic [DEPTH-1:0] w_hitRs;
    logic [DEPTH-1:0] w_hitRt;
    logic [DEPTH-1:0] w_cmpMask;
    logic             w_anyHit;
    logic             w_hazard;
    logic             w_insert;

    // ------------------------------------------------------------------------
    // Per-entry comparators. When the regfile writes before it reads, the WB
    // entry is already visible to decode and is left out of the compare set.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            hazard_cmp u_cmp (
                .entry     (r_entries[gi]),
                .rs        (id_rs),
                .rt        (id_rt),
                .matchRs   (id_match_rs),
                .matchBoth (id_match_both),
                .hitRs     (w_hitRs[gi]),
                .hitRt     (w_hitRt[gi])
            );
            assign w_cmpMask[gi] = !((WB_BYPASS != 0) && (gi == DEPTH - 1));
        end
    endgenerate

    // Multiple matching entries collapse into one hazard; it persists until
    // the youngest matching entry leaves the compare set.
    assign w_anyHit = |((w_hitRs | w_hitRt) & w_cmpMask);

    // A flushed decode instruction never stalls: the redirect kills it.
    assign w_hazard = id_valid & ~flush & w_anyHit;
    assign stall    = w_hazard;
    assign bubble   = w_hazard | flush;

    // Only an instruction actually leaving decode into EX occupies entry[0].
    assign w_insert = id_valid & id_wr_en & ~w_hazard & ~flush;

    // Scoreboard shift: ages every cycle, even while stalled, so hazards drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                r_entries[i] <= r_entries[i-1];
            end
            r_entries[0] <= sb_entry_t'{valid: w_insert, regNum: id_wr_reg};
        end
    end

    // Stall controller: tracks the current run of consecutive stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HZ_IDLE;
            r_stallRun <= '0;
        end else begin
            case (r_state)
                HZ_IDLE: begin
                    if (w_hazard) begin
                        r_state    <= HZ_STALL;
                        r_stallRun <= RUN_W'(1);
                    end else begin
                        r_stallRun <= '0;
                    end
                end
                HZ_STALL: begin
                    if (w_hazard) begin
                        if (r_stallRun != c_maxRun) begin
                            r_stallRun <= r_stallRun + RUN_W'(1);
                        end
                    end else begin
                        r_state    <= HZ_IDLE;
                        r_stallRun <= '0;
                    end
                end
                default: begin
                    r_state    <= HZ_IDLE;
                    r_stallRun <= '0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Every pending write leaves the scoreboard within DEPTH cycles, so a
    // longer stall run means the compare or shift logic is broken.
    always_ff @(posedge clk) begin
        if (rst_n && w_hazard) begin
            assert (r_stallRun < c_maxRun)
                else $error("hazard_scoreboard: stall run longer than DEPTH cycles");
        end
    end
`endif

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stallCycles;

    // Cumulative stall-cycle count, saturating; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCycles <= 16'h0000;
        end else if (w_hazard && (r_stallCycles != 16'hFFFF)) begin
            r_stallCycles <= r_stallCycles + 16'd1;
        end
    end

    assign stall_cycles = r_stallCycles;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule : hazard_scoreboard

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module  : tb_hazard_scoreboard
// Brief   : Directed bench for hazard_scoreboard. Two instances share all
//           inputs: dutA with WB_BYPASS=1 and dutB with WB_BYPASS=0.
//           Compile with HAZARD_STATS_EN to exercise the stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              idValid;
    logic [REG_AW-1:0] idRs;
    logic [REG_AW-1:0] idRt;
    logic              idMatchRs;
    logic              idMatchBoth;
    logic              idWrEn;
    logic [REG_AW-1:0] idWrReg;
    logic              idFlush;

    logic              stallA;
    logic              bubbleA;
    logic [15:0]       cntA;
    logic              stallB;
    logic              bubbleB;
    logic [15:0]       cntB;

    int                total = 0;
    int                bad   = 0;
    logic [15:0]       expA  = 16'h0000;
    logic [15:0]       expB  = 16'h0000;

    hazard_scoreboard #(.WB_BYPASS(1)) dutA (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (idValid),
        .id_rs         (idRs),
        .id_rt         (idRt),
        .id_match_rs   (idMatchRs),
        .id_match_both (idMatchBoth),
        .id_wr_en      (idWrEn),
        .id_wr_reg     (idWrReg),
        .flush         (idFlush),
        .stall         (stallA),
        .bubble        (bubbleA),
        .stall_cycles  (cntA)
    );

    hazard_scoreboard #(.WB_BYPASS(0)) dutB (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (idValid),
        .id_rs         (idRs),
        .id_rt         (idRt),
        .id_match_rs   (idMatchRs),
        .id_match_both (idMatchBoth),
        .id_wr_en      (idWrEn),
        .id_wr_reg     (idWrReg),
        .flush         (idFlush),
        .stall         (stallB),
        .bubble        (bubbleB),
        .stall_cycles  (cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic mrs,
                         input logic mb, input logic wen, input int wreg, input logic fl);
        idValid     = v;
        idRs        = REG_AW'(rs);
        idRt        = REG_AW'(rt);
        idMatchRs   = mrs;
        idMatchBoth = mb;
        idWrEn      = wen;
        idWrReg     = REG_AW'(wreg);
        idFlush     = fl;
    endtask

    // One clock cycle: inputs are already applied at posedge+1; check the
    // combinational outputs mid-cycle, track expected stall counts, advance.
    task automatic cyc(input string tag, input logic eA, input logic eB);
        #3;
        chk({tag, ".stallA"},  {15'd0, stallA},  {15'd0, eA});
        chk({tag, ".bubbleA"}, {15'd0, bubbleA}, {15'd0, eA | idFlush});
        chk({tag, ".stallB"},  {15'd0, stallB},  {15'd0, eB});
        chk({tag, ".bubbleB"}, {15'd0, bubbleB}, {15'd0, eB | idFlush});
        if (eA && expA != 16'hFFFF) expA = expA + 16'd1;
        if (eB && expB != 16'hFFFF) expB = expB + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic chkCnt(input string tag);
`ifdef HAZARD_STATS_EN
        chk({tag, ".cntA"}, cntA, expA);
        chk({tag, ".cntB"}, cntB, expB);
`else
        chk({tag, ".cntA"}, cntA, 16'h0000);
        chk({tag, ".cntB"}, cntB, 16'h0000);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset.stallA",  {15'd0, stallA},  16'h0000);
        chk("reset.bubbleA", {15'd0, bubbleA}, 16'h0000);
        chk("reset.stallB",  {15'd0, stallB},  16'h0000);
        chk("reset.bubbleB", {15'd0, bubbleB}, 16'h0000);
        chkCnt("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW from EX: A stalls 2 cycles, B stalls 3.
        drive(1, 0, 0, 0, 0, 1, 3, 0);
        cyc("raw0", 0, 0);
        drive(1, 3, 1, 0, 1, 1, 4, 0);
        cyc("raw1", 1, 1);
        cyc("raw2", 1, 1);
        cyc("raw3", 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("raw4", 0, 0);
        chkCnt("raw");
        cyc("drain0", 0, 0);
        cyc("drain1", 0, 0);

        // Rt-only source: ignored unless match_both is set.
        drive(1, 0, 0, 0, 0, 1, 5, 0);
        cyc("rt_wr", 0, 0);
        drive(1, 2, 5, 1, 0, 0, 0, 0);
        cyc("rt_rsonly", 0, 0);
        drive(1, 2, 5, 0, 1, 0, 0, 0);
        cyc("rt_both_mem", 1, 1);
        cyc("rt_both_wb", 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rt_idle", 0, 0);

        // Rs hazard via match_rs alone.
        drive(1, 0, 0, 0, 0, 1, 2, 0);
        cyc("rs_wr", 0, 0);
        drive(1, 2, 0, 1, 0, 0, 0, 0);
        cyc("rs_ex", 1, 1);
        cyc("rs_mem", 1, 1);
        cyc("rs_wb", 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rs_idle", 0, 0);

        // Rs == Rt, both hazarding: same timing as a single hit.
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        cyc("same_wr", 0, 0);
        drive(1, 1, 1, 0, 1, 0, 0, 0);
        cyc("same_ex", 1, 1);
        cyc("same_mem", 1, 1);
        cyc("same_wb", 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("same_idle", 0, 0);

        // Flush beats hazard; the flushed write (R7) is never recorded.
        drive(1, 0, 0, 0, 0, 1, 6, 0);
        cyc("fl_wr", 0, 0);
        drive(1, 6, 0, 1, 0, 1, 7, 1);
        cyc("fl_hz", 0, 0);
        drive(1, 7, 7, 0, 1, 0, 0, 0);
        cyc("fl_noins", 0, 0);
        // R6 now only in WB: bypassed for A, one stall for B.
        drive(1, 6, 6, 0, 1, 0, 0, 0);
        cyc("wb_only", 0, 1);
        cyc("wb_clear", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("wb_idle", 0, 0);

        // Two entries hold the same register: one stall run, clears with the youngest.
        drive(1, 0, 0, 0, 0, 1, 4, 0);
        cyc("dup_w1", 0, 0);
        cyc("dup_w2", 0, 0);
        drive(1, 4, 0, 1, 0, 0, 0, 0);
        cyc("dup_c", 1, 1);
        cyc("dup_d", 1, 1);
        cyc("dup_e", 0, 1);
        cyc("dup_f", 0, 0);

        // Flush with no valid decode instruction still bubbles.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("flush_idle", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("idle_mid", 0, 0);
        chkCnt("mid");

`ifdef HAZARD_STATS_EN
        // Saturation: preload near the top, then stall past it.
        force dutA.r_stallCycles = 16'hFFFE;
        force dutB.r_stallCycles = 16'hFFFE;
        #1;
        release dutA.r_stallCycles;
        release dutB.r_stallCycles;
        expA = 16'hFFFE;
        expB = 16'hFFFE;
        drive(1, 0, 0, 0, 0, 1, 3, 0);
        cyc("sat_wr", 0, 0);
        drive(1, 3, 0, 1, 0, 0, 0, 0);
        cyc("sat_ex", 1, 1);
        cyc("sat_mem", 1, 1);
        cyc("sat_wb", 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("sat_idle", 0, 0);
        chk("sat.cntA", cntA, 16'hFFFF);
        chk("sat.cntB", cntB, 16'hFFFF);
`endif

        // Mid-operation reset discards pending entries immediately.
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        cyc("rst_wr", 0, 0);
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        #3;
        chk("prerst.stallA", {15'd0, stallA}, 16'h0001);
        chk("prerst.stallB", {15'd0, stallB}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("inrst.stallA",  {15'd0, stallA},  16'h0000);
        chk("inrst.bubbleA", {15'd0, bubbleA}, 16'h0000);
        chk("inrst.stallB",  {15'd0, stallB},  16'h0000);
        chk("inrst.bubbleB", {15'd0, bubbleB}, 16'h0000);
        expA = 16'h0000;
        expB = 16'h0000;
        chkCnt("inrst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_after", 0, 0);
        chkCnt("rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_scoreboard

`default_nettype wire
